// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: drives both ports of a 1RW1R SRAM macro from two valid/ready request channels,
// zero-fills the array after reset and returns read data through credit-limited FWFT response FIFOs.
module sram_rsp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 4
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic          push,
    input  logic          ready,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic pop;
    assign valid = count != '0;
    assign pop = valid && ready;
    assign dout = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // Credits upstream make a push into a full FIFO unreachable.
    assert property (@(posedge CLK) disable iff (!resetn) !(push && !pop && count == CW'(DEPTH)));
endmodule

module sram_1rw1r_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 4,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [NUM_WMASKS-1:0] p0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic                  init_done
);
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;
    typedef enum logic [1:0] {INIT, DONE_WAIT, RUN} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [1:0] rd0_pipe, rd1_pipe;
    logic [CW-1:0] cnt0, cnt1;
    logic acc0, acc1;
    // Bit 0: read issued to the macro pins; bit 1: macro has captured it, dout sampled next edge.
    assign p0_req_ready = init_done && (cnt0 + CW'(rd0_pipe[0]) + CW'(rd0_pipe[1]) < CW'(RSP_DEPTH));
    assign p1_req_ready = init_done && (cnt1 + CW'(rd1_pipe[0]) + CW'(rd1_pipe[1]) < CW'(RSP_DEPTH));
    assign acc0 = p0_req_valid && p0_req_ready;
    assign acc1 = p1_req_valid && p1_req_ready;
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= INIT_ZERO ? INIT : RUN;
            fill_addr <= '0;
            init_done <= 1'b0;
            csb0 <= 1'b1;
            web0 <= 1'b1;
            wmask0 <= '0;
            addr0 <= '0;
            din0 <= '0;
            csb1 <= 1'b1;
            addr1 <= '0;
            rd0_pipe <= '0;
            rd1_pipe <= '0;
        end else begin
            rd0_pipe <= {rd0_pipe[0], acc0 && !p0_req_we};
            rd1_pipe <= {rd1_pipe[0], acc1};
            csb0 <= !acc0;
            csb1 <= !acc1;
            if (acc0) begin
                web0 <= !p0_req_we;
                wmask0 <= p0_req_wmask;
                addr0 <= p0_req_addr;
                din0 <= p0_req_wdata;
            end
            if (acc1) addr1 <= p1_req_addr;
            case (state)
                INIT: begin
                    csb0 <= 1'b0;
                    web0 <= 1'b0;
                    wmask0 <= '1;
                    din0 <= '0;
                    addr0 <= fill_addr;
                    fill_addr <= fill_addr + ADDR_WIDTH'(1);
                    if (&fill_addr) state <= DONE_WAIT;
                end
                DONE_WAIT: begin
                    state <= RUN;
                    init_done <= 1'b1;
                end
                default: init_done <= 1'b1;
            endcase
        end
    end
    sram_rsp_fifo #(.W(DATA_WIDTH), .DEPTH(RSP_DEPTH), .CW(CW)) u_rsp0 (
        .CLK(CLK), .resetn(resetn), .push(rd0_pipe[1]), .ready(p0_rsp_ready), .din(dout0),
        .dout(p0_rsp_rdata), .valid(p0_rsp_valid), .count(cnt0)
    );
    sram_rsp_fifo #(.W(DATA_WIDTH), .DEPTH(RSP_DEPTH), .CW(CW)) u_rsp1 (
        .CLK(CLK), .resetn(resetn), .push(rd1_pipe[1]), .ready(p1_rsp_ready), .din(dout1),
        .dout(p1_rsp_rdata), .valid(p1_rsp_valid), .count(cnt1)
    );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: directed bench with a behavioural SRAM macro, a timeline/credit model of the
// controller checked every cycle, and literal expectations for the key scenarios.
module tb_sram_1rw1r_ctrl;
    logic CLK = 1'b0, resetn;
    logic p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
    logic [3:0] p0_req_wmask;
    logic [7:0] p0_req_addr, p1_req_addr, addr0, addr1;
    logic [31:0] p0_req_wdata, p0_rsp_rdata, p1_rsp_rdata, din0, dout0, dout1;
    logic p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
    logic csb0, web0, csb1, init_done;
    logic [3:0] wmask0;

    int n_cmp = 0, n_bad = 0;

    sram_1rw1r_ctrl dut (
        .CLK(CLK), .resetn(resetn),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_wmask(p0_req_wmask), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1), .init_done(init_done)
    );

    always #5 CLK = ~CLK;

    // Behavioural macro: both ports sample at the rising edge; a same-edge read sees the old word.
    logic [31:0] mac [256];
    logic [31:0] mw;
    initial for (int i = 0; i < 256; i++) mac[i] <= 32'hBAD0_0000 | i;
    always @(posedge CLK) begin
        if (!csb1) dout1 <= mac[addr1];
        if (!csb0) begin
            if (web0) dout0 <= mac[addr0];
            else begin
                mw = mac[addr0];
                for (int i = 0; i < 4; i++) if (wmask0[i]) mw[8*i +: 8] = din0[8*i +: 8];
                mac[addr0] <= mw;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Model: user-visible array contents plus outstanding reads with their due sample index.
    typedef struct {logic [31:0] d; int t;} rsp_t;
    rsp_t q0[$], q1[$];
    logic [31:0] gm [256];
    logic [31:0] gw;
    int rel = 0, iaddr = 0;
    logic done, v0, v1;
    always begin
        @(negedge CLK);
        #4;
        if (!resetn) begin
            q0.delete();
            q1.delete();
            rel = 0;
            iaddr = 0;
        end else begin
            rel++;
            if (rel == 1) for (int i = 0; i < 256; i++) gm[i] = '0;
            done = rel >= 258;
            chk("init_done", init_done, done);
            if (!done && !csb0) begin
                chk("fill pins", {web0, wmask0, din0, addr0}, {1'b0, 4'hF, 32'h0, iaddr[7:0]});
                iaddr++;
            end
            if (!done) chk("fill csb1", csb1, 1);
            chk("p0_req_ready", p0_req_ready, done && q0.size() < 4);
            chk("p1_req_ready", p1_req_ready, done && q1.size() < 4);
            v0 = q0.size() > 0 && q0[0].t <= rel;
            v1 = q1.size() > 0 && q1[0].t <= rel;
            chk("p0_rsp_valid", p0_rsp_valid, v0);
            chk("p1_rsp_valid", p1_rsp_valid, v1);
            if (p0_rsp_valid && v0) chk("p0_rsp_rdata", p0_rsp_rdata, q0[0].d);
            if (p1_rsp_valid && v1) chk("p1_rsp_rdata", p1_rsp_rdata, q1[0].d);
            if (p0_rsp_valid && p0_rsp_ready && v0) void'(q0.pop_front());
            if (p1_rsp_valid && p1_rsp_ready && v1) void'(q1.pop_front());
            if (p1_req_valid && p1_req_ready) q1.push_back('{d: gm[p1_req_addr], t: rel + 3});
            if (p0_req_valid && p0_req_ready) begin
                if (!p0_req_we) q0.push_back('{d: gm[p0_req_addr], t: rel + 3});
                else begin
                    gw = gm[p0_req_addr];
                    for (int i = 0; i < 4; i++) if (p0_req_wmask[i]) gw[8*i +: 8] = p0_req_wdata[8*i +: 8];
                    gm[p0_req_addr] = gw;
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, " csb/web"}, {csb0, csb1, web0}, 3'b111);
        chk({tag, " wmask0/din0"}, {wmask0, din0}, 0);
        chk({tag, " addr0/addr1"}, {addr0, addr1}, 0);
        chk({tag, " ready/valid/done"}, {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, init_done}, 0);
        chk({tag, " rsp_rdata"}, {p0_rsp_rdata, p1_rsp_rdata}, 0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (1) begin
            #4;
            if (init_done) break;
            n++;
            if (n > 400) begin
                fail(tag);
                break;
            end
            @(negedge CLK);
        end
        chk({tag, " latency"}, n, 257);
        chk({tag, " fill writes"}, iaddr, 256);
        @(negedge CLK);
    endtask

    task automatic p0_issue(input logic we, input logic [3:0] m, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        p0_req_valid = 1'b1;
        p0_req_we = we;
        p0_req_wmask = m;
        p0_req_addr = a;
        p0_req_wdata = d;
        #4;
        while (!p0_req_ready && n < 50) begin
            @(negedge CLK);
            #4;
            n++;
        end
        if (n == 50) fail("p0 request");
        @(negedge CLK);
        p0_req_valid = 1'b0;
    endtask

    task automatic p1_issue(input logic [7:0] a);
        int n = 0;
        p1_req_valid = 1'b1;
        p1_req_addr = a;
        #4;
        while (!p1_req_ready && n < 50) begin
            @(negedge CLK);
            #4;
            n++;
        end
        if (n == 50) fail("p1 request");
        @(negedge CLK);
        p1_req_valid = 1'b0;
    endtask

    task automatic p0_expect(input logic [31:0] exp, input string name, output int lat);
        lat = 0;
        while (1) begin
            #4;
            if (p0_rsp_valid) begin
                chk(name, p0_rsp_rdata, exp);
                break;
            end
            lat++;
            if (lat > 20) begin
                fail(name);
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic p1_expect(input logic [31:0] exp, input string name);
        int n = 0;
        while (1) begin
            #4;
            if (p1_rsp_valid) begin
                chk(name, p1_rsp_rdata, exp);
                break;
            end
            n++;
            if (n > 20) begin
                fail(name);
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    initial begin
        int lat, a;
        resetn = 1'b1;
        {p0_req_valid, p0_req_we, p0_req_wmask, p0_req_addr, p0_req_wdata} = '0;
        {p1_req_valid, p1_req_addr} = '0;
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        #1 resetn = 1'b0;
        #1 chk_reset("por");
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        wait_init("init");

        p1_issue(8'h7F);
        p1_expect(32'h0, "p1 read 7F after fill");

        p0_issue(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        p0_issue(1'b0, 4'h0, 8'h10, 32'h0);
        p0_expect(32'hDEADBEEF, "p0 read 10", lat);
        chk("p0 read latency", lat, 2);

        p0_issue(1'b1, 4'b0101, 8'h10, 32'h11223344);
        p0_issue(1'b0, 4'h0, 8'h10, 32'h0);
        p0_expect(32'hDE22BE44, "p0 masked read 10", lat);

        for (int i = 0; i < 8; i++) p0_issue(1'b1, 4'hF, i[7:0], 32'hC0DE_0000 + i);
        p1_rsp_ready = 1'b0;
        a = 0;
        p1_req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            p1_req_addr = a[7:0];
            #4;
            if (p1_req_ready) a++;
            @(negedge CLK);
        end
        p1_req_valid = 1'b0;
        chk("p1 burst accepted", a, 4);
        chk("p1 ready low when full", p1_req_ready, 0);
        p1_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) p1_expect(32'hC0DE_0000 + i, "p1 burst data");
        for (int i = 4; i < 8; i++) begin
            p1_issue(i[7:0]);
            p1_expect(32'hC0DE_0000 + i, "p1 tail data");
        end

        p0_req_valid = 1'b1;
        p0_req_we = 1'b1;
        p0_req_wmask = 4'hF;
        p0_req_addr = 8'h20;
        p0_req_wdata = 32'hA5A5A5A5;
        p1_req_valid = 1'b1;
        p1_req_addr = 8'h20;
        #4;
        chk("collision readies", {p0_req_ready, p1_req_ready}, 2'b11);
        @(negedge CLK);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        p1_expect(32'h0, "p1 collision old data");
        p1_issue(8'h20);
        p1_expect(32'hA5A5A5A5, "p1 read after write");

        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
        p1_issue(8'h10);
        p1_issue(8'h20);
        p1_issue(8'h7F);
        repeat (3) @(negedge CLK);
        p0_req_valid = 1'b1;
        p0_req_we = 1'b0;
        p0_req_addr = 8'h10;
        repeat (2) @(negedge CLK);
        resetn = 1'b0;
        #1 chk_reset("mid");
        p0_req_valid = 1'b0;
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        wait_init("reinit");
        repeat (5) @(negedge CLK);
        p0_issue(1'b0, 4'h0, 8'h10, 32'h0);
        p0_expect(32'h0, "p0 read 10 after refill", lat);
        p1_issue(8'h20);
        p1_expect(32'h0, "p1 read 20 after refill");
        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_1rw1r_ctrl.md
Name: sram_1rw1r_ctrl

Overview:
- Synchronous initiator that drives both ports of the 1RW1R 32x256 SRAM macro (sram_1rw1r_32_256_8_sky130 pin set) on behalf of a fabric-side user.
- Converts two valid/ready request channels (port 0 read/write, port 1 read-only) into macro pin activity and returns read data through per-port response FIFOs with backpressure.
- After reset it runs a zero-fill sweep over the whole array, then raises init_done.
- Sits between fabric BRAM-tile logic and the macro; CLK feeds both macro clocks.

Parameters:
- DATA_WIDTH, 32, word width; must equal macro data width.
- ADDR_WIDTH, 8, word address width; array depth = 1<<ADDR_WIDTH.
- NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8).
- RSP_DEPTH, 4, entries per response FIFO; minimum 2.
- INIT_ZERO, 1, 1 = run zero-fill after reset; 0 = init_done at first edge after reset release.

Ports:
- CLK  in  1  single clock; also drives macro clk0/clk1.
- resetn  in  1  asynchronous active-low reset.
- p0_req_valid  in  1  port-0 request valid.
- p0_req_ready  out  1  port-0 request accepted when valid&ready at rising CLK.
- p0_req_we  in  1  1 = write, 0 = read.
- p0_req_wmask  in  NUM_WMASKS  byte enables (writes only).
- p0_req_addr  in  ADDR_WIDTH  word address.
- p0_req_wdata  in  DATA_WIDTH  write data.
- p0_rsp_valid  out  1  port-0 read data available.
- p0_rsp_ready  in  1  consumer pops port-0 response.
- p0_rsp_rdata  out  DATA_WIDTH  port-0 read data.
- p1_req_valid / p1_req_ready / p1_req_addr  in/out/in  1/1/ADDR_WIDTH  port-1 read request channel.
- p1_rsp_valid / p1_rsp_ready / p1_rsp_rdata  out/in/out  1/1/DATA_WIDTH  port-1 response channel.
- csb0, web0  out  1  macro port-0 chip select / write enable, active low.
- wmask0  out  NUM_WMASKS  macro port-0 write mask.
- addr0  out  ADDR_WIDTH  macro port-0 address.
- din0  out  DATA_WIDTH  macro port-0 write data.
- dout0  in  DATA_WIDTH  macro port-0 read data.
- csb1  out  1  macro port-1 chip select, active low.
- addr1  out  ADDR_WIDTH  macro port-1 address.
- dout1  in  DATA_WIDTH  macro port-1 read data.
- init_done  out  1  zero-fill complete; requests accepted only when high.

Behaviour:
- Reset values (async, resetn=0): csb0=csb1=web0=1; wmask0=0, addr0/addr1=0, din0=0; both req_ready=0, both rsp_valid=0, both rsp_rdata=0, init_done=0; FIFOs empty; in-flight counters 0; FSM=INIT (INIT_ZERO=1) or RUN (INIT_ZERO=0).
- Mid-operation reset: in-flight reads and FIFO contents are discarded; zero-fill restarts at address 0.
- FSM INIT: one write per cycle, csb0=0, web0=0, wmask0=all ones, din0=0, addr0 = 0..DEPTH-1. Port 1 idle (csb1=1). After the write to DEPTH-1 is issued, go to DONE_WAIT for 1 cycle (macro commit), then RUN with init_done=1. Zero-fill takes DEPTH+1 cycles.
- FSM RUN: init_done stays 1 until reset.
- Macro pins are registered: a request accepted at edge N drives its pins during cycle N..N+1; the macro captures them at edge N+1.
- Cycles with no accepted request: csb=1 and other pins hold their previous values.
- Read latency: read accepted at edge N; dout sampled at edge N+2 into that port's FIFO; rsp_valid=1 after edge N+2.
- The macro holds dout until its next access; this controller never re-samples dout outside a scheduled capture.
- Credit rule per port: req_ready = init_done & (fifo_count + reads_in_flight < RSP_DEPTH). Computed from registered state only, so it has no combinational path from req_valid.
- Port-0 writes consume no credit. A write is accepted whenever init_done=1 and p0_req_ready would be 1 for a read.
- Throughput: one request per port per cycle; ports are independent.
- Same-address collision: a p0 write and a p1 read to the same address accepted on the same edge return the old data on port 1.
- Response FIFOs are first-word-fall-through: rsp_rdata is valid whenever rsp_valid=1. Pop on rsp_valid&rsp_ready. A simultaneous push and pop keeps the count unchanged.
- Overflow is impossible by the credit rule; an overflow is flagged by a simulation-only assertion.
- Accepted p0 write data/wmask are passed unmodified to din0/wmask0; wmask=0 produces a no-op access.

Test Plan:
- Reset release with INIT_ZERO=1 -> addr0 sweeps 0..255 with web0=0, wmask0=4'hF, din0=0; init_done rises exactly 257 cycles after the first INIT edge; p1 read of address 0x7F then returns 32'h0.
- p0 write addr 0x10, data 32'hDEADBEEF, wmask 4'hF; next cycle p0 read 0x10 -> p0_rsp_valid 2 cycles after read acceptance, rdata 32'hDEADBEEF.
- p0 write 0x10 with wmask 4'b0101, data 32'h11223344 over 32'hDEADBEEF; read back -> 32'hDE22BE44.
- Back-to-back p1 reads of addresses 0..7 with p1_rsp_ready=0 -> exactly RSP_DEPTH=4 accepted; p1_req_ready=0 thereafter; release rsp_ready -> data returned in order, no loss.
- Same-edge p0 write 0x20 = 32'hA5A5A5A5 and p1 read 0x20 (old value 0) -> p1 returns 0; a later p1 read returns 32'hA5A5A5A5.
- Assert resetn=0 with 2 reads in flight and 3 FIFO entries -> all outputs at reset values immediately; after release, zero-fill reruns and no stale responses appear.
